// File: rtl/focus_pkg.sv
// Shared constants, FSM state type and helpers for the focus-value statistic path.
package focus_pkg;

  // ITU-style luma weights: Y = (77R + 150G + 29B) >> 8
  localparam int LUMA_KR    = 77;
  localparam int LUMA_KG    = 150;
  localparam int LUMA_KB    = 29;
  localparam int LUMA_SHIFT = 8;

  localparam int H_START_DEF = 160;
  localparam int H_END_DEF   = 479;
  localparam int V_START_DEF = 120;
  localparam int V_END_DEF   = 359;
  localparam int THRESH_DEF  = 8;
  localparam int ACC_W_DEF   = 32;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LATCH = 2'd2
  } frame_state_t;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/focus_value_stat_if.sv
// Focus-value output channel: data/flags from the statistic block, ready from the step controller.
interface focus_value_stat_if
  import focus_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);
  logic [ACC_W-1:0] FV_DATA;
  logic             FV_SAT;
  logic             FV_VALID;
  logic             FV_READY;
  logic             FV_OVR;
  logic [7:0]       FV_PEAK;

  modport master (
    output FV_DATA, FV_SAT, FV_VALID, FV_OVR, FV_PEAK,
    input  FV_READY
  );

  modport slave (
    input  FV_DATA, FV_SAT, FV_VALID, FV_OVR, FV_PEAK,
    output FV_READY
  );
endinterface

// File: rtl/focus_luma.sv
// Stage-1 RGB to 8-bit luma converter with registered output; shared with the display mixer.
module focus_luma
  import focus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] y
);
  // Weights sum to 256, so the 16-bit sum never overflows for 8-bit inputs.
  logic [15:0] sum;

  always_comb begin
    sum = 16'(LUMA_KR) * 16'(r) + 16'(LUMA_KG) * 16'(g) + 16'(LUMA_KB) * 16'(b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= sum[LUMA_SHIFT +: 8];
    end
  end
endmodule

// File: rtl/focus_value_stat.sv
// Per-frame focus value: luma gradient energy inside a centre window, one result per VS-to-VS frame.
// Define FOCUS_STAT_PEAK_EN to track the largest counted gradient on FV_PEAK; otherwise FV_PEAK is 0.
module focus_value_stat
  import focus_pkg::*;
#(
  parameter int H_START = H_START_DEF,
  parameter int H_END   = H_END_DEF,
  parameter int V_START = V_START_DEF,
  parameter int V_END   = V_END_DEF,
  parameter int THRESH  = THRESH_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic       VIDEO_CLK,
  input  logic       RESET,
  input  logic       VS,
  input  logic       HS,
  input  logic       DE,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  focus_value_stat_if.master fv
);
  localparam int SUM_W = ACC_W + 1;

  logic             hs_d, vs_d, de_d;
  logic             hs_fall, vs_fall, de_fall;
  logic             vs_fall_r;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             in_win;

  logic [7:0]       y_s1;
  logic             de_s1, win_s1, first_s1, act_s1;

  logic [7:0]       y_prev;
  logic [7:0]       d_cur;
  logic [7:0]       d_s2;
  logic             cnt_s2;

  logic [ACC_W-1:0] acc, acc_base;
  logic [SUM_W-1:0] acc_sum;
  logic             sat, sat_base;
  logic             latch_now;

  frame_state_t     state;
  logic [1:0]       drain_cnt;
  logic             frame_active;

  always_comb begin
    hs_fall = hs_d & ~HS;
    vs_fall = vs_d & ~VS;
    de_fall = de_d & ~DE;
    in_win  = (h_cnt >= CNT_W'(H_START)) && (h_cnt <= CNT_W'(H_END)) &&
              (v_cnt >= CNT_W'(V_START)) && (v_cnt <= CNT_W'(V_END));
  end

  // Edge delays start at 0 so a sync already low when reset releases is not mistaken for a fall.
  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
      vs_fall_r <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
    end else begin
      hs_d      <= HS;
      vs_d      <= VS;
      de_d      <= DE;
      vs_fall_r <= vs_fall;
      if (hs_fall) begin
        h_cnt <= '0;
      end else if (DE) begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (vs_fall) begin
        v_cnt <= '0;
      end else if (de_fall) begin
        v_cnt <= v_cnt + 1'b1;
      end
    end
  end

  focus_luma u_luma (
    .clk (VIDEO_CLK),
    .rst (RESET),
    .r   (iR),
    .g   (iG),
    .b   (iB),
    .y   (y_s1)
  );

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      de_s1    <= 1'b0;
      win_s1   <= 1'b0;
      first_s1 <= 1'b0;
      act_s1   <= 1'b0;
    end else begin
      de_s1    <= DE;
      win_s1   <= in_win;
      first_s1 <= (h_cnt == '0);
      act_s1   <= frame_active;
    end
  end

  always_comb begin
    d_cur = first_s1 ? 8'd0 : abs_diff(y_s1, y_prev);
  end

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      y_prev <= '0;
      d_s2   <= '0;
      cnt_s2 <= 1'b0;
    end else begin
      d_s2   <= d_cur;
      cnt_s2 <= de_s1 && win_s1 && act_s1 && (d_cur > 8'(THRESH));
      if (de_s1) begin
        y_prev <= y_s1;
      end
    end
  end

  // The LATCH cycle hands the old sum out while a pixel of the next frame may already add in.
  always_comb begin
    latch_now = (state == LATCH);
    acc_base  = latch_now ? '0 : acc;
    sat_base  = latch_now ? 1'b0 : sat;
    acc_sum   = {1'b0, acc_base} + SUM_W'(d_s2);
  end

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (cnt_s2 && acc_sum[ACC_W]) begin
      acc <= '1;
      sat <= 1'b1;
    end else if (cnt_s2) begin
      acc <= acc_sum[ACC_W-1:0];
      sat <= sat_base;
    end else begin
      acc <= acc_base;
      sat <= sat_base;
    end
  end

  // Only a VS fall that ends a frame begun after reset closes it; the first fall just opens one.
  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      frame_active <= 1'b0;
      fv.FV_DATA   <= '0;
      fv.FV_SAT    <= 1'b0;
      fv.FV_VALID  <= 1'b0;
      fv.FV_OVR    <= 1'b0;
    end else begin
      fv.FV_OVR <= 1'b0;
      if (fv.FV_VALID && fv.FV_READY) begin
        fv.FV_VALID <= 1'b0;
      end
      if (vs_fall_r) begin
        frame_active <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (vs_fall_r && frame_active) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state <= LATCH;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        LATCH: begin
          state       <= IDLE;
          fv.FV_DATA  <= acc;
          fv.FV_SAT   <= sat;
          fv.FV_VALID <= 1'b1;
          fv.FV_OVR   <= fv.FV_VALID && !fv.FV_READY;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FOCUS_STAT_PEAK_EN
  logic [7:0] peak, peak_base;

  always_comb begin
    peak_base = latch_now ? 8'd0 : peak;
  end

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      peak       <= '0;
      fv.FV_PEAK <= '0;
    end else begin
      if (cnt_s2 && (d_s2 > peak_base)) begin
        peak <= d_s2;
      end else begin
        peak <= peak_base;
      end
      if (latch_now) begin
        fv.FV_PEAK <= peak;
      end
    end
  end
`else
  assign fv.FV_PEAK = '0;
`endif

endmodule

// File: tb/tb_focus_value_stat.sv
// Directed bench for focus_value_stat on a reduced 16x12 frame with an 8x6 window.
module tb_focus_value_stat;
  import focus_pkg::*;

  localparam int TB_H_START = 4;
  localparam int TB_H_END   = 11;
  localparam int TB_V_START = 3;
  localparam int TB_V_END   = 8;
  localparam int TB_THRESH  = 8;
  localparam int LINES      = 12;
  localparam int COLS       = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs, hs, de;
  logic [7:0] r, g, b;
  logic       ready;

  int  tests = 0;
  int  fails = 0;
  bit  pending = 1'b0;

  always #5 clk = ~clk;

  focus_value_stat_if #(.ACC_W(32)) fv0 ();
  focus_value_stat_if #(.ACC_W(12)) fv1 ();

  assign fv0.FV_READY = ready;
  assign fv1.FV_READY = ready;

  focus_value_stat #(
    .H_START(TB_H_START), .H_END(TB_H_END), .V_START(TB_V_START), .V_END(TB_V_END),
    .THRESH(TB_THRESH), .ACC_W(32)
  ) dut0 (
    .VIDEO_CLK(clk), .RESET(rst), .VS(vs), .HS(hs), .DE(de),
    .iR(r), .iG(g), .iB(b), .fv(fv0)
  );

  focus_value_stat #(
    .H_START(TB_H_START), .H_END(TB_H_END), .V_START(TB_V_START), .V_END(TB_V_END),
    .THRESH(TB_THRESH), .ACC_W(12)
  ) dut1 (
    .VIDEO_CLK(clk), .RESET(rst), .VS(vs), .HS(hs), .DE(de),
    .iR(r), .iG(g), .iB(b), .fv(fv1)
  );

  typedef struct {
    logic [7:0] on_r;
    logic [7:0] on_g;
    logic [7:0] on_b;
    logic [7:0] off_y;
    int         exp_fv;
    int         exp_fv12;
    bit         exp_sat12;
    int         exp_peak;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Odd offsets inside the window carry the "on" colour; everything else is flat grey off_y.
  task automatic applyStimulus(input vec_t v, input int first_line, input int last_line);
    for (int line = first_line; line <= last_line; line++) begin
      tick(); hs = 1'b0;
      tick(); tick(); hs = 1'b1;
      tick(); tick();
      for (int col = 0; col < COLS; col++) begin
        de = 1'b1;
        if (col >= TB_H_START && col <= TB_H_END && ((col - TB_H_START) % 2 == 1)) begin
          r = v.on_r; g = v.on_g; b = v.on_b;
        end else begin
          r = v.off_y; g = v.off_y; b = v.off_y;
        end
        tick();
      end
      de = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0;
      tick(); tick(); tick();
    end
  endtask

  task automatic vs_only();
    tick(); vs = 1'b0;
    tick(); tick(); vs = 1'b1;
    repeat (8) tick();
    checkOutput("no_close_on_first_vs", 32'(fv0.FV_VALID), 32'(pending));
  endtask

  // VS is sampled low at edge T; FV_VALID must appear after edge T+5 and not before.
  task automatic close_frame(input bit ready_at_latch);
    bit exp_ovr;
    exp_ovr = pending && !ready_at_latch;
    tick(); vs = 1'b0;
    tick();
    tick(); vs = 1'b1;
    tick(); tick(); tick();
    checkOutput("valid_before_latch", 32'(fv0.FV_VALID), 32'(pending));
    if (ready_at_latch) ready = 1'b1;
    tick();
    ready = 1'b0;
    checkOutput("valid_after_latch", 32'(fv0.FV_VALID), 32'd1);
    checkOutput("ovr_at_latch", 32'(fv0.FV_OVR), 32'(exp_ovr));
    pending = 1'b1;
    tick();
    checkOutput("ovr_single_cycle", 32'(fv0.FV_OVR), 32'd0);
  endtask

  task automatic consume();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checkOutput("valid_after_ready", 32'(fv0.FV_VALID), 32'd0);
    pending = 1'b0;
  endtask

  initial begin
    // on_r, on_g, on_b, off_y, exp_fv (32b), exp_fv12, exp_sat12, exp_peak
    vecs[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 0,     0,    1'b0, 0};
    vecs[1] = '{8'd100, 8'd100, 8'd100, 8'd0,   4200,  4095, 1'b1, 100};
    vecs[2] = '{8'd8,   8'd8,   8'd8,   8'd0,   0,     0,    1'b0, 0};
    vecs[3] = '{8'd9,   8'd9,   8'd9,   8'd0,   378,   378,  1'b0, 9};
    vecs[4] = '{8'd255, 8'd255, 8'd255, 8'd0,   10710, 4095, 1'b1, 255};
    vecs[5] = '{8'd200, 8'd0,   8'd0,   8'd0,   2520,  2520, 1'b0, 60};
    vecs[6] = '{8'd0,   8'd100, 8'd0,   8'd0,   2436,  2436, 1'b0, 58};
    vecs[7] = '{8'd0,   8'd0,   8'd255, 8'd0,   1176,  1176, 1'b0, 28};
    vecs[8] = '{8'd50,  8'd50,  8'd50,  8'd0,   2100,  2100, 1'b0, 50};

    rst = 1'b1; vs = 1'b1; hs = 1'b1; de = 1'b0;
    r = 8'd0; g = 8'd0; b = 8'd0; ready = 1'b0;
    repeat (3) tick();
    checkOutput("reset_fv_data", fv0.FV_DATA, 32'd0);
    checkOutput("reset_fv_sat", 32'(fv0.FV_SAT), 32'd0);
    checkOutput("reset_fv_valid", 32'(fv0.FV_VALID), 32'd0);
    checkOutput("reset_fv_ovr", 32'(fv0.FV_OVR), 32'd0);
    checkOutput("reset_fv_peak", 32'(fv0.FV_PEAK), 32'd0);
    rst = 1'b0;
    tick();

    // Pixels before the first VS fall must not count toward the first frame.
    applyStimulus(vecs[1], 0, LINES - 1);
    vs_only();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], 0, LINES - 1);
      close_frame(1'b0);
      checkOutput($sformatf("fv_data_v%0d", i), fv0.FV_DATA, 32'(vecs[i].exp_fv));
      checkOutput($sformatf("fv_sat_v%0d", i), 32'(fv0.FV_SAT), 32'd0);
      checkOutput($sformatf("fv12_data_v%0d", i), 32'(fv1.FV_DATA), 32'(vecs[i].exp_fv12));
      checkOutput($sformatf("fv12_sat_v%0d", i), 32'(fv1.FV_SAT), 32'(vecs[i].exp_sat12));
`ifdef FOCUS_STAT_PEAK_EN
      checkOutput($sformatf("fv_peak_v%0d", i), 32'(fv0.FV_PEAK), 32'(vecs[i].exp_peak));
`else
      checkOutput($sformatf("fv_peak_v%0d", i), 32'(fv0.FV_PEAK), 32'd0);
`endif
      consume();
    end

    // Two frames with no consumer: second latch overwrites and pulses FV_OVR once.
    applyStimulus(vecs[1], 0, LINES - 1);
    close_frame(1'b0);
    applyStimulus(vecs[3], 0, LINES - 1);
    close_frame(1'b0);
    checkOutput("ovr_data_second", fv0.FV_DATA, 32'd378);
    checkOutput("ovr_valid_held", 32'(fv0.FV_VALID), 32'd1);
    // Ready in the latch cycle: old value transfers, new one loads, no overwrite flag.
    applyStimulus(vecs[8], 0, LINES - 1);
    close_frame(1'b1);
    checkOutput("latch_ready_data", fv0.FV_DATA, 32'd2100);
    consume();

    // Reset in mid-frame with an unconsumed value pending.
    applyStimulus(vecs[1], 0, LINES - 1);
    close_frame(1'b0);
    applyStimulus(vecs[1], 0, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pending = 1'b0;
    checkOutput("midreset_fv_data", fv0.FV_DATA, 32'd0);
    checkOutput("midreset_fv_sat", 32'(fv1.FV_SAT), 32'd0);
    checkOutput("midreset_fv_valid", 32'(fv0.FV_VALID), 32'd0);
    checkOutput("midreset_fv_ovr", 32'(fv0.FV_OVR), 32'd0);
    checkOutput("midreset_fv_peak", 32'(fv0.FV_PEAK), 32'd0);
    applyStimulus(vecs[1], 5, LINES - 1);
    vs_only();
    applyStimulus(vecs[8], 0, LINES - 1);
    close_frame(1'b0);
    checkOutput("post_reset_data", fv0.FV_DATA, 32'd2100);
    checkOutput("post_reset_data12", 32'(fv1.FV_DATA), 32'd2100);
    checkOutput("post_reset_sat12", 32'(fv1.FV_SAT), 32'd0);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
